// File: rtl/lcd_sched_pkg.sv
// Shared types and default timing for the LCD request scheduler.
package lcd_sched_pkg;

    localparam int NUM_REQ = 2;

    localparam int DEF_SETUP_CYCLES      = 2;
    localparam int DEF_EN_HIGH_CYCLES    = 12;
    localparam int DEF_NIBBLE_GAP_CYCLES = 50;
    localparam int DEF_CMD_WAIT_CYCLES   = 2000;
    localparam int DEF_CLEAR_WAIT_CYCLES = 82000;

    typedef enum logic [2:0] {
        IDLE,
        HI_SETUP,
        HI_PULSE,
        HI_GAP,
        LO_SETUP,
        LO_PULSE,
        EXEC_WAIT
    } lcd_state_t;

    // Byte captured at the handshake and replayed as two nibbles
    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } lcd_req_t;

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Clear display and return home need the long execution wait
    function automatic logic is_slow_cmd(input lcd_req_t r);
        return !r.rs && (r.data == 8'h01 || r.data == 8'h02);
    endfunction

endpackage

// File: rtl/lcd_rr_arbiter.sv
// Two-way round-robin grant; ptr names the requester favoured on a tie.
module lcd_rr_arbiter
    import lcd_sched_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               ptr,
    output logic [NUM_REQ-1:0] grant
);

    // Lone requester always wins, a tie goes to the favoured one
    always_comb begin
        grant = '0;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = '0;
        endcase
    end

endmodule

// File: rtl/lcd_request_scheduler.sv
// Arbitrates two byte-write requesters onto a 4-bit HD44780-style bus,
// sequencing setup, enable pulse and execution wait for both nibbles.
module lcd_request_scheduler
    import lcd_sched_pkg::*;
#(
    parameter int SETUP_CYCLES      = DEF_SETUP_CYCLES,
    parameter int EN_HIGH_CYCLES    = DEF_EN_HIGH_CYCLES,
    parameter int NIBBLE_GAP_CYCLES = DEF_NIBBLE_GAP_CYCLES,
    parameter int CMD_WAIT_CYCLES   = DEF_CMD_WAIT_CYCLES,
    parameter int CLEAR_WAIT_CYCLES = DEF_CLEAR_WAIT_CYCLES
) (
    input  logic                 clock,
    input  logic                 reset_active_low,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_rs,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [3:0]           lcd_data,
    output logic                 lcd_rs,
    output logic                 lcd_rw,
    output logic                 lcd_en,
    output logic                 lcd_on,
    output logic                 busy
);

    localparam int MAX_CYCLES = max_i(max_i(max_i(SETUP_CYCLES, EN_HIGH_CYCLES),
                                            max_i(NIBBLE_GAP_CYCLES, CMD_WAIT_CYCLES)),
                                      CLEAR_WAIT_CYCLES);
    localparam int CNT_W = $clog2(MAX_CYCLES) + 1;

    // Counter reload values: a state lasting N cycles loads N-1
    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(EN_HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(NIBBLE_GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_CMD   = CNT_W'(CMD_WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_CLEAR = CNT_W'(CLEAR_WAIT_CYCLES - 1);

    lcd_state_t         state;
    logic [CNT_W-1:0]   cnt;
    logic               rr_ptr;
    lcd_req_t           cur;
    lcd_req_t           sel;
    logic [NUM_REQ-1:0] grant;
    logic               xfer;
    logic               cnt_done;

    lcd_rr_arbiter u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    // Grant is only offered while idle and out of reset
    assign req_ready = (state == IDLE && reset_active_low) ? grant : '0;
    assign xfer      = |(req_valid & req_ready);
    assign cnt_done  = (cnt == '0);
    assign busy      = (state != IDLE);
    assign lcd_rw    = 1'b0;

    // Pick the granted requester's rs and byte for capture
    always_comb begin
        sel = '0;
        if (grant[1]) begin
            sel.rs   = req_rs[1];
            sel.data = req_data[15:8];
        end else begin
            sel.rs   = req_rs[0];
            sel.data = req_data[7:0];
        end
    end

    // Transfer FSM: outputs change on the same edge as the state they belong to
    always_ff @(posedge clock) begin
        if (!reset_active_low) begin
            state    <= IDLE;
            cnt      <= '0;
            rr_ptr   <= 1'b0;
            cur      <= '0;
            lcd_data <= '0;
            lcd_rs   <= 1'b0;
            lcd_en   <= 1'b0;
            lcd_on   <= 1'b0;
        end else begin
            lcd_on <= 1'b1;
            if (state != IDLE && !cnt_done)
                cnt <= cnt - CNT_W'(1);
            case (state)
                IDLE: begin
                    if (xfer) begin
                        cur      <= sel;
                        rr_ptr   <= grant[0];  // favour the loser next time
                        lcd_data <= sel.data[7:4];
                        lcd_rs   <= sel.rs;
                        cnt      <= LD_SETUP;
                        state    <= HI_SETUP;
                    end
                end
                HI_SETUP: begin
                    if (cnt_done) begin
                        lcd_en <= 1'b1;
                        cnt    <= LD_EN;
                        state  <= HI_PULSE;
                    end
                end
                HI_PULSE: begin
                    if (cnt_done) begin
                        lcd_en <= 1'b0;
                        cnt    <= LD_GAP;
                        state  <= HI_GAP;
                    end
                end
                HI_GAP: begin
                    if (cnt_done) begin
                        lcd_data <= cur.data[3:0];
                        cnt      <= LD_SETUP;
                        state    <= LO_SETUP;
                    end
                end
                LO_SETUP: begin
                    if (cnt_done) begin
                        lcd_en <= 1'b1;
                        cnt    <= LD_EN;
                        state  <= LO_PULSE;
                    end
                end
                LO_PULSE: begin
                    if (cnt_done) begin
                        lcd_en <= 1'b0;
                        cnt    <= is_slow_cmd(cur) ? LD_CLEAR : LD_CMD;
                        state  <= EXEC_WAIT;
                    end
                end
                EXEC_WAIT: begin
                    if (cnt_done)
                        state <= IDLE;
                end
                default: begin
                    lcd_en <= 1'b0;
                    cnt    <= '0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_request_scheduler.sv
// Directed bench for lcd_request_scheduler: per-cycle waveform model of each
// byte, arbitration order, clear/home wait selection and mid-byte reset.
module tb_lcd_request_scheduler;

    localparam int S   = 2;
    localparam int H   = 12;
    localparam int G   = 50;
    localparam int CMD = 2000;
    localparam int CLR = 8200;   // shortened clear wait keeps the run short
    localparam int LO_END = 2*S + 2*H + G;   // last LO_PULSE cycle (78)

    logic        clock = 1'b0;
    logic        reset_active_low;
    logic [1:0]  req_valid;
    logic [1:0]  req_rs;
    logic [15:0] req_data;
    logic [1:0]  req_ready;
    logic [3:0]  lcd_data;
    logic        lcd_rs, lcd_rw, lcd_en, lcd_on, busy;

    int checks = 0;
    int errors = 0;

    lcd_request_scheduler #(
        .SETUP_CYCLES      (S),
        .EN_HIGH_CYCLES    (H),
        .NIBBLE_GAP_CYCLES (G),
        .CMD_WAIT_CYCLES   (CMD),
        .CLEAR_WAIT_CYCLES (CLR)
    ) dut (
        .clock            (clock),
        .reset_active_low (reset_active_low),
        .req_valid        (req_valid),
        .req_rs           (req_rs),
        .req_data         (req_data),
        .req_ready        (req_ready),
        .lcd_data         (lcd_data),
        .lcd_rs           (lcd_rs),
        .lcd_rw           (lcd_rw),
        .lcd_en           (lcd_en),
        .lcd_on           (lcd_on),
        .busy             (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expected {lcd_on, busy, lcd_en, lcd_rs, lcd_data} in cycle c after the handshake
    function automatic logic [7:0] exp_wave(input int c, input logic rs,
                                            input logic [7:0] d, input int idle_c);
        logic       en;
        logic [3:0] nib;
        logic       bz;
        en  = (c > S && c <= S + H) || (c > 2*S + H + G && c <= LO_END);
        nib = (c <= S + H + G) ? d[7:4] : d[3:0];
        bz  = (c < idle_c);
        return {1'b1, bz, en, rs, nib};
    endfunction

    // Present a byte on requester r, expect grant pattern exp_rdy, then follow
    // the whole transfer cycle by cycle up to and including the return to IDLE
    task automatic send(input int r, input logic rs, input logic [7:0] d,
                        input logic drop, input logic [1:0] exp_rdy, input int wcyc);
        int idle_c;
        idle_c = LO_END + 1 + wcyc;
        req_valid[r] = 1'b1;
        req_rs[r]    = rs;
        if (r == 0) req_data[7:0]  = d;
        else        req_data[15:8] = d;
        #1;
        chk("grant", {30'b0, req_ready}, {30'b0, exp_rdy});
        tick();
        if (drop) req_valid[r] = 1'b0;
        for (int c = 1; c <= idle_c; c++) begin
            chk("wave", {24'b0, lcd_on, busy, lcd_en, lcd_rs, lcd_data},
                {24'b0, exp_wave(c, rs, d, idle_c)});
            if (c < idle_c) begin
                chk("rdy_busy", {30'b0, req_ready}, 32'd0);
                tick();
            end
        end
    endtask

    // Invariants checked every cycle away from the active edge
    always @(negedge clock) begin
        chk("rw_zero", {31'b0, lcd_rw}, 32'd0);
        chk("rdy_both", {31'b0, (req_ready == 2'b11)}, 32'd0);
    end

    initial begin
        reset_active_low = 1'b0;
        req_valid        = '0;
        req_rs           = '0;
        req_data         = '0;
        #1;
        repeat (3) tick();
        chk("rst_out", {24'b0, lcd_on, busy, lcd_en, lcd_rs, lcd_data}, 32'd0);
        chk("rst_rdy", {30'b0, req_ready}, 32'd0);
        reset_active_low = 1'b1;
        tick();
        chk("on_after_rst", {31'b0, lcd_on}, 32'd1);
        chk("idle_busy", {31'b0, busy}, 32'd0);

        // Both valid after reset: req0, then req1 at 2079, then req0 again
        req_valid[1]    = 1'b1;
        req_rs[1]       = 1'b1;
        req_data[15:8]  = 8'h48;
        send(0, 1'b0, 8'h38, 1'b1, 2'b01, CMD);
        send(1, 1'b1, 8'h48, 1'b1, 2'b10, CMD);
        req_valid[1] = 1'b1;
        send(0, 1'b0, 8'h38, 1'b1, 2'b01, CMD);
        req_valid[1] = 1'b0;

        // Data write 'A' and the long-wait command selection boundaries
        send(0, 1'b1, 8'h41, 1'b1, 2'b01, CMD);
        send(0, 1'b0, 8'h01, 1'b1, 2'b01, CLR);
        send(0, 1'b0, 8'h02, 1'b1, 2'b01, CLR);
        send(0, 1'b1, 8'h01, 1'b1, 2'b01, CMD);
        send(1, 1'b0, 8'h03, 1'b1, 2'b10, CMD);

        // Requester 1 holds valid: transfers back-to-back at 0, 2079, 4158
        send(1, 1'b1, 8'h55, 1'b0, 2'b10, CMD);
        send(1, 1'b1, 8'h55, 1'b0, 2'b10, CMD);
        send(1, 1'b1, 8'h55, 1'b1, 2'b10, CMD);

        // Reset during HI_PULSE at cycle 8, held for three cycles
        req_valid[0]  = 1'b1;
        req_rs[0]     = 1'b1;
        req_data[7:0] = 8'h41;
        #1;
        chk("grant_pre_rst", {30'b0, req_ready}, 32'd1);
        tick();
        req_valid[0] = 1'b0;
        repeat (7) tick();
        chk("en_cycle8", {31'b0, lcd_en}, 32'd1);
        reset_active_low = 1'b0;
        req_valid        = 2'b11;
        for (int c = 9; c <= 10; c++) begin
            tick();
            chk("rst_mid_out", {24'b0, lcd_on, busy, lcd_en, lcd_rs, lcd_data}, 32'd0);
            chk("rst_mid_rdy", {30'b0, req_ready}, 32'd0);
        end
        tick();
        reset_active_low = 1'b1;
        #1;
        chk("rr_ptr_reset", {30'b0, req_ready}, 32'd1);
        req_valid = 2'b00;
        tick();
        chk("on_after_rel", {31'b0, lcd_on}, 32'd1);
        chk("idle_after_rel", {31'b0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
